// File: rtl/conv_tile_scheduler.sv
// ---------------------------------------------------------------------------
// conv_tile_scheduler
//
// Top-level sequencer for the convolution PE array controller. A layer start
// latches the layer configuration, issues one config-load pulse to the PE FSM,
// then launches one tile at a time. A tile is launched only when both input
// buffers are ready and the output FIFO has room, and it retires on
// writeback completion. After the last tile a final kick drives the PE FSM
// into FINISH, and the block waits for end_conv. A watchdog guards the RUN
// and WAIT_END phases. Abort returns the block to IDLE from any state.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, abort              layer start (IDLE only), abort (any state)
//   cfg_ci/cfg_co/cfg_tile_num layer configuration, sampled on accepted start
//   ifm_ready, wgt_ready      buffers hold the next tile
//   ofm_full                  output FIFO almost full (stalls the PE)
//   tile_wb_done              current tile fully written back
//   pe_end_conv               end_conv from the PE FSM
//   pe_start_conv             one-cycle config-load pulse
//   pe_start_again            one-cycle tile-launch / final kick pulse
//   pe_stall                  stall to the PE FSM (follows ofm_full)
//   pe_cfg_ci/pe_cfg_co/pe_tile_num  latched configuration
//   tile_idx                  index of the tile in flight / next tile
//   busy, done, err           status: not idle, completion pulse, sticky error
// ---------------------------------------------------------------------------
module conv_tile_scheduler #(
    parameter int S       = 64,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_ci,
    input  logic [31:0]      cfg_co,
    input  logic [31:0]      cfg_tile_num,
    input  logic             ifm_ready,
    input  logic             wgt_ready,
    input  logic             ofm_full,
    input  logic             tile_wb_done,
    input  logic             pe_end_conv,
    output logic             pe_start_conv,
    output logic             pe_start_again,
    output logic             pe_stall,
    output logic [31:0]      pe_cfg_ci,
    output logic [31:0]      pe_cfg_co,
    output logic [31:0]      pe_tile_num,
    output logic [CNT_W-1:0] tile_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_BUF = 3'd2,
        ST_KICK     = 3'd3,
        ST_RUN      = 3'd4,
        ST_FINAL    = 3'd5,
        ST_WAIT_END = 3'd6
    } state_t;

    state_t             state_r, state_next_s;
    logic [WD_W-1:0]    wd_r, wd_next_s;
    logic [CNT_W-1:0]   tile_idx_r, tile_idx_next_s;
    logic [CNT_W-1:0]   num_tiles_r;
    logic               err_r, err_next_s;
    logic               done_next_s;
    logic               latch_cfg_s;
    logic               conv_r, again_r, busy_r, done_r;
    logic [31:0]        ci_r, co_r, tn_r;
    logic [CNT_W-1:0]   num_tiles_s;

    // Truncating tile count derived from the raw config at start time.
    assign num_tiles_s = CNT_W'(cfg_tile_num / 32'(S));

    // Stall passes straight through so the PE reacts in the same cycle.
    assign pe_stall = ofm_full;

    // Next-state, watchdog, tile counter and status decode.
    always_comb begin
        state_next_s    = state_r;
        wd_next_s       = wd_r;
        tile_idx_next_s = tile_idx_r;
        err_next_s      = err_r;
        done_next_s     = 1'b0;
        latch_cfg_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    latch_cfg_s     = 1'b1;
                    tile_idx_next_s = {CNT_W{1'b0}};
                    err_next_s      = 1'b0;
                    state_next_s    = ST_LOAD;
                end else begin
                    state_next_s    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_WAIT_BUF;
            end
            ST_WAIT_BUF: begin
                // Completion check comes first so zero-tile layers skip kicks.
                if (tile_idx_r == num_tiles_r) begin
                    state_next_s = ST_FINAL;
                end else if (ifm_ready && wgt_ready && !ofm_full) begin
                    state_next_s = ST_KICK;
                end else begin
                    state_next_s = ST_WAIT_BUF;
                end
            end
            ST_KICK: begin
                wd_next_s    = {WD_W{1'b0}};
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                // Writeback completion wins over a coincident watchdog expiry.
                if (tile_wb_done) begin
                    tile_idx_next_s = tile_idx_r + CNT_W'(1);
                    state_next_s    = ST_WAIT_BUF;
                end else if (!ofm_full) begin
                    if (wd_r == WD_LAST) begin
                        err_next_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        wd_next_s    = wd_r + WD_W'(1);
                    end
                end else begin
                    wd_next_s = wd_r;
                end
            end
            ST_FINAL: begin
                wd_next_s    = {WD_W{1'b0}};
                state_next_s = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (pe_end_conv) begin
                    done_next_s  = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (!ofm_full) begin
                    if (wd_r == WD_LAST) begin
                        err_next_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        wd_next_s    = wd_r + WD_W'(1);
                    end
                end else begin
                    wd_next_s = wd_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Abort overrides everything: tile_idx, err and watchdog hold.
        if (abort) begin
            state_next_s    = ST_IDLE;
            wd_next_s       = wd_r;
            tile_idx_next_s = tile_idx_r;
            err_next_s      = err_r;
            done_next_s     = 1'b0;
            latch_cfg_s     = 1'b0;
        end else begin
            latch_cfg_s     = latch_cfg_s;
        end
    end

    // State, counters, latched config and registered output decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wd_r        <= {WD_W{1'b0}};
            tile_idx_r  <= {CNT_W{1'b0}};
            num_tiles_r <= {CNT_W{1'b0}};
            err_r       <= 1'b0;
            conv_r      <= 1'b0;
            again_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ci_r        <= 32'd0;
            co_r        <= 32'd0;
            tn_r        <= 32'd0;
        end else begin
            state_r    <= state_next_s;
            wd_r       <= wd_next_s;
            tile_idx_r <= tile_idx_next_s;
            err_r      <= err_next_s;
            // Pulses are decoded from the next state so they coincide with it.
            conv_r     <= (state_next_s == ST_LOAD);
            again_r    <= (state_next_s == ST_KICK) || (state_next_s == ST_FINAL);
            busy_r     <= (state_next_s != ST_IDLE);
            done_r     <= done_next_s;
            if (latch_cfg_s) begin
                ci_r        <= cfg_ci;
                co_r        <= cfg_co;
                tn_r        <= cfg_tile_num;
                num_tiles_r <= num_tiles_s;
            end
        end
    end

    assign pe_start_conv  = conv_r;
    assign pe_start_again = again_r;
    assign pe_cfg_ci      = ci_r;
    assign pe_cfg_co      = co_r;
    assign pe_tile_num    = tn_r;
    assign tile_idx       = tile_idx_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;

endmodule
